// File: rtl/qtpa_pkg.sv
// Shared QTPA types and constants for the IQ0 dispatch path.
package qtpa_pkg;

    localparam int IQ_DEPTH      = 8;
    localparam int IQ_PIPE_DEPTH = 4;
    localparam int QTPS_INSN_W   = 32;

    // addi x0, x0, 0
    localparam logic [QTPS_INSN_W-1:0] QTPS_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IQ_IDLE  = 2'd0,
        IQ_RUN   = 2'd1,
        IQ_DRAIN = 2'd2
    } iq_state_t;

endpackage

// File: rtl/qtpa_iq_fifo.sv
// IQ0 circular buffer: storage, wrapping pointers, occupancy and flags.
module qtpa_iq_fifo #(
    parameter int DEPTH  = 8,
    parameter int INSN_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [INSN_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [INSN_W-1:0]          o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSN_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/qtpa_iq_dispatch.sv
// IQ0 producer: buffers instructions and issues one word (or NOP) per cycle.
// Optional perf counters enabled by defining QTPA_IQ_PERF_EN.
module qtpa_iq_dispatch
    import qtpa_pkg::*;
#(
    parameter int DEPTH      = IQ_DEPTH,
    parameter int INSN_W     = QTPS_INSN_W,
    parameter int PIPE_DEPTH = IQ_PIPE_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push_valid,
    input  logic [INSN_W-1:0]      i_push_insn,
    output logic                   o_push_ready,
    input  logic                   i_start,
    input  logic                   i_drain,
    input  logic                   i_flush,
    output logic [INSN_W-1:0]      o_insn_out,
    output logic                   o_insn_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [31:0]            o_issued_cnt,
    output logic [31:0]            o_bubble_cnt
);

    localparam int TW = $clog2(PIPE_DEPTH + 1);
    localparam logic [INSN_W-1:0] NOP = INSN_W'(QTPS_NOP);

    iq_state_t         r_state;
    iq_state_t         w_state_nx;
    logic [TW-1:0]     r_tail;
    logic [TW-1:0]     w_tail_nx;
    logic              r_done;
    logic              w_done_nx;
    logic [INSN_W-1:0] r_insn;
    logic              r_valid;
    logic [INSN_W-1:0] w_rdata;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign o_push_ready = !w_full && (r_state != IQ_DRAIN);
    assign w_push = i_push_valid && o_push_ready && !i_flush;
    assign w_pop  = (r_state != IQ_IDLE) && !w_empty && !i_flush;

    qtpa_iq_fifo #(
        .DEPTH  (DEPTH),
        .INSN_W (INSN_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_flush),
        .i_push  (w_push),
        .i_wdata (i_push_insn),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Tail counts NOP cycles after the queue empties during a drain.
    always_comb begin
        w_state_nx = r_state;
        w_tail_nx  = TW'(PIPE_DEPTH);
        w_done_nx  = 1'b0;
        unique case (r_state)
            IQ_IDLE: begin
                if (i_drain) begin
                    w_state_nx = IQ_DRAIN;
                end else if (i_start) begin
                    w_state_nx = IQ_RUN;
                end
            end
            IQ_RUN: begin
                if (i_drain) begin
                    w_state_nx = IQ_DRAIN;
                end
            end
            IQ_DRAIN: begin
                if (w_empty) begin
                    if (r_tail <= TW'(1)) begin
                        w_state_nx = IQ_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_tail_nx = r_tail - 1'b1;
                    end
                end
            end
            default: w_state_nx = IQ_IDLE;
        endcase
        if (i_flush) begin
            w_state_nx = IQ_IDLE;
            w_tail_nx  = TW'(PIPE_DEPTH);
            w_done_nx  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IQ_IDLE;
            r_tail  <= TW'(PIPE_DEPTH);
            r_done  <= 1'b0;
            r_insn  <= NOP;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tail  <= w_tail_nx;
            r_done  <= w_done_nx;
            r_insn  <= w_pop ? w_rdata : NOP;
            r_valid <= w_pop;
        end
    end

    assign o_insn_out   = r_insn;
    assign o_insn_valid = r_valid;
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_busy       = (r_state != IQ_IDLE);
    assign o_done       = r_done;

`ifdef QTPA_IQ_PERF_EN
    logic [31:0] r_issued;
    logic [31:0] r_bubble;

    // Saturating; flush intentionally leaves the history intact.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_issued <= '0;
            r_bubble <= '0;
        end else begin
            if (w_pop && (r_issued != '1)) begin
                r_issued <= r_issued + 1'b1;
            end
            if ((r_state != IQ_IDLE) && !w_pop && !i_flush
                && (r_bubble != '1)) begin
                r_bubble <= r_bubble + 1'b1;
            end
        end
    end

    assign o_issued_cnt = r_issued;
    assign o_bubble_cnt = r_bubble;
`else
    assign o_issued_cnt = '0;
    assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_qtpa_iq_dispatch.sv
// Self-checking bench for qtpa_iq_dispatch against a queue-based model.
module tb_qtpa_iq_dispatch;
    import qtpa_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int PD    = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic [W-1:0]  push_insn = '0;
    logic          start = 1'b0;
    logic          drain = 1'b0;
    logic          flush = 1'b0;
    logic          push_ready;
    logic [W-1:0]  insn_out;
    logic          insn_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;
    logic          done;
    logic [31:0]   issued_cnt;
    logic [31:0]   bubble_cnt;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] m_q[$];
    int           m_state;
    int           m_tail;
    logic [W-1:0] m_out;
    logic         m_valid;
    logic         m_done;
    longint       m_iss;
    longint       m_bub;

    always #5 clk = ~clk;

    qtpa_iq_dispatch #(
        .DEPTH(DEPTH), .INSN_W(W), .PIPE_DEPTH(PD)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_push_valid(push_valid), .i_push_insn(push_insn),
        .o_push_ready(push_ready),
        .i_start(start), .i_drain(drain), .i_flush(flush),
        .o_insn_out(insn_out), .o_insn_valid(insn_valid),
        .o_count(count), .o_full(full), .o_empty(empty),
        .o_busy(busy), .o_done(done),
        .o_issued_cnt(issued_cnt), .o_bubble_cnt(bubble_cnt)
    );

    // Model state: 0 idle, 1 run, 2 drain.
    task automatic model_step();
        int n;
        bit pop;
        bit rdy;
        if (rst) begin
            m_q.delete(); m_state = 0; m_tail = PD;
            m_out = QTPS_NOP; m_valid = 0; m_done = 0;
            m_iss = 0; m_bub = 0;
        end else if (flush) begin
            m_q.delete(); m_state = 0; m_tail = PD;
            m_out = QTPS_NOP; m_valid = 0; m_done = 0;
        end else begin
            n = m_q.size();
            rdy = (n < DEPTH) && (m_state != 2);
            pop = (m_state != 0) && (n > 0);
            m_done = 0;
            if (pop) begin
                m_out = m_q.pop_front(); m_valid = 1; m_iss++;
            end else begin
                m_out = QTPS_NOP; m_valid = 0;
                if (m_state != 0) m_bub++;
            end
            case (m_state)
                0: if (drain) begin m_state = 2; m_tail = PD; end
                   else if (start) m_state = 1;
                1: if (drain) begin m_state = 2; m_tail = PD; end
                default: if (!pop) begin
                    m_tail--;
                    if (m_tail == 0) begin
                        m_state = 0; m_done = 1; m_tail = PD;
                    end
                end
            endcase
            if (push_valid && rdy) m_q.push_back(push_insn);
        end
    endtask

    function automatic logic [31:0] e_iss();
`ifdef QTPA_IQ_PERF_EN
        return m_iss[31:0];
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] e_bub();
`ifdef QTPA_IQ_PERF_EN
        return m_bub[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; push_valid = 0; start = 0; drain = 0; flush = 0;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic push_n(input int n, output logic [W-1:0] w[12]);
        for (int i = 0; i < n; i++) begin
            w[i] = $urandom;
            push_valid = 1; push_insn = w[i];
            tick();
        end
        push_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
        repeat (5) tick();
        checks++;
        if (insn_out !== QTPS_NOP) begin
            failures++;
            $display("FAIL reset_insn got=%h exp=%h", insn_out, QTPS_NOP);
        end
        checks++;
        if (insn_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got v=%b d=%b b=%b exp 0 0 0",
                     insn_valid, done, busy);
        end
        checks++;
        if (empty !== 1'b1 || count !== '0 || push_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_queue got e=%b c=%0d r=%b exp 1 0 1",
                     empty, count, push_ready);
        end
        checks++;
        if (issued_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_perf got %0d %0d exp 0 0",
                     issued_cnt, bubble_cnt);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] w[12];
        do_reset();
        push_n(3, w);
        checks++;
        if (count !== 4'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_fill got c=%0d b=%b exp 3 0", count, busy);
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (insn_out !== w[i] || insn_valid !== 1'b1) begin
                failures++;
                $display("FAIL basic_issue%0d got=%h/%b exp=%h/1",
                         i, insn_out, insn_valid, w[i]);
            end
        end
        tick();
        checks++;
        if (insn_out !== QTPS_NOP || insn_valid !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL basic_after got=%h/%b c=%0d exp=%h/0 c=0",
                     insn_out, insn_valid, count, QTPS_NOP);
        end
    endtask

    task automatic test_full_wrap();
        logic [W-1:0] w[12];
        int idx;
        int got;
        int cyc;
        bit acc;
        do_reset();
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) begin
            push_valid = 1; push_insn = w[i];
            tick();
        end
        idx = DEPTH;
        push_insn = w[idx];
        checks++;
        if (full !== 1'b1 || push_ready !== 1'b0 || count !== 4'd8) begin
            failures++;
            $display("FAIL wrap_full got f=%b r=%b c=%0d exp 1 0 8",
                     full, push_ready, count);
        end
        tick(); tick();
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            failures++;
            $display("FAIL wrap_hold got c=%0d f=%b exp 8 1", count, full);
        end
        start = 1; got = 0; cyc = 0;
        while (got < 12 && cyc < 60) begin
            acc = push_valid && push_ready;
            tick();
            start = 0;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 12) push_insn = w[idx];
                else push_valid = 0;
            end
            checks++;
            if (insn_out !== m_out || insn_valid !== m_valid) begin
                failures++;
                $display("FAIL wrap_model got=%h/%b exp=%h/%b",
                         insn_out, insn_valid, m_out, m_valid);
            end
            if (insn_valid) begin
                checks++;
                if (insn_out !== w[got]) begin
                    failures++;
                    $display("FAIL wrap_order%0d got=%h exp=%h",
                             got, insn_out, w[got]);
                end
                got++;
            end
        end
        push_valid = 0;
        checks++;
        if (got != 12) begin
            failures++;
            $display("FAIL wrap_timeout got=%0d exp=12", got);
        end
    endtask

    task automatic test_drain();
        logic [W-1:0] w[12];
        int nvalid;
        int nop;
        int cyc;
        do_reset();
        push_n(2, w);
        start = 1;
        tick();
        start = 0; drain = 1;
        tick();
        drain = 0;
        push_valid = 1; push_insn = $urandom;
        nvalid = insn_valid ? 1 : 0;
        nop = insn_valid ? 0 : 1;
        checks++;
        if (push_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_enter got r=%b b=%b exp 0 1",
                     push_ready, busy);
        end
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (insn_valid) nvalid++;
            else nop++;
            checks++;
            if (insn_out !== m_out || done !== m_done
                || (busy && push_ready !== 1'b0)) begin
                failures++;
                $display("FAIL drain_cyc%0d got=%h d=%b r=%b exp=%h d=%b",
                         cyc, insn_out, done, push_ready, m_out, m_done);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_done got d=%b b=%b exp 1 0", done, busy);
        end
        checks++;
        if (nvalid != 2 || nop != PD || count !== '0) begin
            failures++;
            $display("FAIL drain_seq got iss=%0d nop=%0d c=%0d exp 2 %0d 0",
                     nvalid, nop, count, PD);
        end
        push_valid = 0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL drain_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] w[12];
        do_reset();
        push_n(5, w);
        start = 1;
        tick();
        start = 0;
        tick(); tick();
        checks++;
        if (insn_out !== w[1] || count !== 4'd3) begin
            failures++;
            $display("FAIL flush_pre got=%h c=%0d exp=%h c=3",
                     insn_out, count, w[1]);
        end
        flush = 1; push_valid = 1; push_insn = $urandom;
        tick();
        flush = 0; push_valid = 0;
        checks++;
        if (insn_out !== QTPS_NOP || insn_valid !== 1'b0
            || count !== '0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_out got=%h/%b c=%0d exp=%h/0 c=0",
                     insn_out, insn_valid, count, QTPS_NOP);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_state got b=%b d=%b exp 0 0", busy, done);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || insn_valid !== 1'b0 || count !== '0) begin
                failures++;
                $display("FAIL flush_idle%0d got d=%b v=%b c=%0d exp 0 0 0",
                         i, done, insn_valid, count);
            end
        end
    endtask

    task automatic test_perf();
        logic [W-1:0] w[12];
        int cyc;
        do_reset();
        push_n(3, w);
        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        drain = 1;
        tick();
        drain = 0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL perf_timeout got=%b exp=1", done);
        end
        checks++;
`ifdef QTPA_IQ_PERF_EN
        if (issued_cnt !== 32'd3 || bubble_cnt !== 32'd7) begin
            failures++;
            $display("FAIL perf_cnt got %0d %0d exp 3 7",
                     issued_cnt, bubble_cnt);
        end
`else
        if (issued_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_off got %0d %0d exp 0 0",
                     issued_cnt, bubble_cnt);
        end
`endif
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (issued_cnt !== e_iss() || bubble_cnt !== e_bub()) begin
            failures++;
            $display("FAIL perf_flush got %0d %0d exp %0d %0d",
                     issued_cnt, bubble_cnt, e_iss(), e_bub());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            push_valid = ($urandom % 3) != 0;
            push_insn  = $urandom;
            start = ($urandom % 6) == 0;
            drain = ($urandom % 25) == 0;
            flush = ($urandom % 60) == 0;
            tick();
            checks++;
            if (insn_out !== m_out || insn_valid !== m_valid
                || done !== m_done || busy !== (m_state != 0)
                || count !== CW'(m_q.size())
                || full !== (m_q.size() == DEPTH)
                || empty !== (m_q.size() == 0)
                || push_ready !== (m_q.size() < DEPTH && m_state != 2)
                || issued_cnt !== e_iss() || bubble_cnt !== e_bub()) begin
                failures++;
                $display("FAIL rand%0d got=%h/%b d=%b b=%b c=%0d i=%0d u=%0d exp=%h/%b d=%b s=%0d c=%0d i=%0d u=%0d",
                         i, insn_out, insn_valid, done, busy, count,
                         issued_cnt, bubble_cnt, m_out, m_valid, m_done,
                         m_state, m_q.size(), e_iss(), e_bub());
            end
        end
        push_valid = 0; start = 0; drain = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_drain();
        test_flush();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qtpa_iq_dispatch.md
Name: qtpa_iq_dispatch

Overview:
- Instruction queue (IQ0) producer side: buffers instructions written by the host/fetch path and drives the QTPS core's 32-bit instruction input one word per cycle.
- Inserts the NOP encoding whenever no instruction is issued.
- Run/drain state machine lets the controller stop issue and learn when every issued instruction has retired through writeback.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- INSN_W, 32, instruction width; must match core instruction port.
- PIPE_DEPTH, 4, NOP cycles after the last issue before retire is guaranteed (decode -> issue -> execute -> writeback).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_valid  in  1  host offers push_insn
- push_insn  in  INSN_W  instruction to enqueue
- push_ready  out  1  queue accepts; transfer when push_valid && push_ready
- start  in  1  pulse: IDLE -> RUN
- drain  in  1  pulse: request drain-and-retire
- flush  in  1  pulse: discard queue contents, abort
- insn_out  out  INSN_W  registered instruction to core
- insn_valid  out  1  insn_out carries a dequeued instruction (not a NOP bubble)
- count  out  $clog2(DEPTH)+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: drain complete
- issued_cnt  out  32  perf: instructions issued
- bubble_cnt  out  32  perf: NOPs issued while busy

Behaviour:
- Reset (sync, rst=1 at edge):
  - state = IDLE; rd/wr pointers and count = 0.
  - insn_out = QTPS_NOP; insn_valid = 0; done = 0; perf counters = 0.
- Storage: circular buffer; pointers wrap modulo DEPTH; count is 0..DEPTH inclusive.
- Push:
  - push_ready = !full && state != DRAIN; depends only on registered state, never combinationally on pop.
  - Accepted word written at wr_ptr on the edge.
- Pop (issue): in RUN or DRAIN with count > 0 at an edge:
  - insn_out <= mem[rd_ptr]; insn_valid <= 1; rd_ptr++.
  - Otherwise insn_out <= QTPS_NOP; insn_valid <= 0.
- Latency and simultaneous events:
  - No bypass: a word accepted at edge k into an empty queue in RUN appears on insn_out after edge k+1.
  - Simultaneous push and pop: count unchanged; both pointers advance.
- FSM:
  - IDLE: no pop. start -> RUN. drain -> DRAIN. If both assert, drain wins.
  - RUN: pop each cycle when non-empty. drain -> DRAIN. start ignored.
  - DRAIN:
    - Pop until empty. Then tail counter loads PIPE_DEPTH and counts down one per NOP cycle.
    - At tail = 0: -> IDLE with done = 1 for exactly that cycle.
    - start/drain ignored.
- Flush (highest priority after rst), on the edge:
  - Pointers and count cleared; insn_out <= QTPS_NOP; insn_valid <= 0; state = IDLE; done stays 0.
  - A push presented in the flush cycle is dropped.
- Issue order is strictly FIFO; no hazard checking here (core forwarding handles WB->EX).

Optional Feature:
- Macro QTPA_IQ_PERF_EN.
- Defined:
  - issued_cnt increments on each edge where insn_valid is set.
  - bubble_cnt increments on each edge where state != IDLE and a NOP is issued.
  - Both saturate at 2^32-1 and are cleared by rst only; flush does not clear them.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- qtpa_pkg gains:
  - QTPS_NOP constant (INSN_W-bit NOP encoding).
  - iq_state_t enum {IQ_IDLE, IQ_RUN, IQ_DRAIN}.
  - IQ_DEPTH default constant.
- One sub-module: qtpa_iq_fifo (storage, pointers, count, full/empty, push/pop/clear ports); the FSM, tail counter and perf counters stay in qtpa_iq_dispatch.

Test Plan:
- Reset then idle 5 cycles -> insn_out = QTPS_NOP, insn_valid = 0, empty = 1, busy = 0, done = 0.
- In IDLE push 3 words A, B, C, then start -> A, B, C on insn_out on consecutive cycles with insn_valid = 1, then NOP; count returns 0.
- Push DEPTH = 8 words while IDLE -> full = 1, push_ready = 0; a 9th push_valid is held and not accepted. Start, and keep pushing during pops -> wrap past index 7, order preserved, 12 words issued in order.
- RUN with 2 queued, assert drain -> 2 issues, then exactly 4 NOP cycles, done high 1 cycle, busy falls with it; push_ready = 0 throughout DRAIN.
- RUN with 5 queued, assert flush mid-stream -> next insn_out = NOP, count = 0, state IDLE, no done pulse; a push in the flush cycle is not stored.
- QTPA_IQ_PERF_EN defined: push 3, start, idle 2 cycles, then drain -> issued_cnt = 3; bubble_cnt counts only busy NOP cycles.
